// File: rtl/processor_sw_debounce.sv
// Purpose : two-flop synchronizer plus per-bit stability debouncer for slide switches; feeds PIO in_port and emits rise/fall pulses.
// Latency : a level held from edge k is visible on sw_stable after edge k+1+DEBOUNCE_CYCLES (k+2 with SW_DEBOUNCE_BYPASS_EN).
// Backpressure: none; free-running level conditioner. Optional macro SW_DEBOUNCE_BYPASS_EN removes the counters.
module processor_sw_debounce #(
    parameter int                 WIDTH           = 1,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter int                 CNT_W           = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Plain two-flop synchronizer; nothing sits between the stages so metastability has a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef SW_DEBOUNCE_BYPASS_EN

    // Inputs are trusted clean: the stable level simply follows the synchronizer output.
    always_comb begin
        stable_d = sync2_q;
    end

`else

    // DEBOUNCE_CYCLES may be 2^CNT_W, so the terminal count always fits in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-bit stability counting: any agreement clears the count, the terminal count accepts the new level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Counter state; cleared by reset so a half-finished count is never resumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

`endif

    // Edge pulses are derived from the next stable value so they line up with the cycle the new level appears.
    always_comb begin
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    // Stable level and edge pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;

endmodule

// File: tb/tb_processor_sw_debounce.sv
// Purpose : directed self-checking bench for processor_sw_debounce, WIDTH=2, DEBOUNCE_CYCLES=8.
// Latency : checks are taken 1 ns after the rising edge; inputs change at the same point.
// Backpressure: not applicable.
module tb_processor_sw_debounce;

    localparam int WIDTH = 2;
    localparam int DEB   = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    int n_checks;
    int n_fail;

    processor_sw_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4),
        .RESET_VALUE     (2'b00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic [1:0] r, input logic [1:0] f);
        check({tag, ".stable"}, {6'b0, sw_stable}, {6'b0, st});
        check({tag, ".rise"},   {6'b0, sw_rise},   {6'b0, r});
        check({tag, ".fall"},   {6'b0, sw_fall},   {6'b0, f});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        sw_raw   = 2'b11;
        #2;
        // Asynchronous reset effect before any clock edge.
        check_outs("rst_noclk", 2'b00, 2'b00, 2'b00);
        step(3);
        check_outs("rst_held", 2'b00, 2'b00, 2'b00);
        reset_n = 1'b1;

`ifdef SW_DEBOUNCE_BYPASS_EN
        // Bypass: stable follows sync2 one edge later.
        sw_raw = 2'b00;
        step(4);
        check_outs("byp_idle", 2'b00, 2'b00, 2'b00);
        sw_raw = 2'b01;
        step(1);
        sw_raw = 2'b00;
        check_outs("byp_k", 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("byp_k1", 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("byp_k2", 2'b01, 2'b01, 2'b00);
        step(1);
        check_outs("byp_k3", 2'b00, 2'b00, 2'b01);
        step(1);
        check_outs("byp_k4", 2'b00, 2'b00, 2'b00);
`else
        // Release with 11 held: acceptance after the 10th edge.
        step(9);
        check_outs("rel_9", 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("rel_10", 2'b11, 2'b11, 2'b00);
        step(1);
        check_outs("rel_11", 2'b11, 2'b00, 2'b00);

        // Both bits fall together.
        sw_raw = 2'b00;
        step(9);
        check_outs("fall_9", 2'b11, 2'b00, 2'b00);
        step(1);
        check_outs("fall_10", 2'b00, 2'b00, 2'b11);
        step(2);

        // Clean step on bit0.
        sw_raw = 2'b01;
        step(9);
        check_outs("step0_9", 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("step0_10", 2'b01, 2'b01, 2'b00);
        step(1);
        check_outs("step0_11", 2'b01, 2'b00, 2'b00);

        // Bounce on bit1: 5 high, 2 low, then held high.
        sw_raw = 2'b11;
        step(5);
        check_outs("bnc_hi", 2'b01, 2'b00, 2'b00);
        sw_raw = 2'b01;
        step(2);
        check_outs("bnc_lo", 2'b01, 2'b00, 2'b00);
        sw_raw = 2'b11;
        step(9);
        check_outs("bnc_9", 2'b01, 2'b00, 2'b00);
        step(1);
        check_outs("bnc_10", 2'b11, 2'b10, 2'b00);
        step(1);
        check_outs("bnc_11", 2'b11, 2'b00, 2'b00);

        // Short pulse train on bit0 (period 4 < 8): no change, no pulses.
        for (int i = 0; i < 6; i++) begin
            sw_raw = 2'b10;
            step(2);
            sw_raw = 2'b11;
            step(2);
            check_outs("train", 2'b11, 2'b00, 2'b00);
        end

        // Prepare bit1 low, then opposite edges on the same cycle.
        sw_raw = 2'b01;
        step(12);
        check_outs("prep", 2'b01, 2'b00, 2'b00);
        sw_raw = 2'b10;
        step(9);
        check_outs("opp_9", 2'b01, 2'b00, 2'b00);
        step(1);
        check_outs("opp_10", 2'b10, 2'b10, 2'b01);
        step(1);
        check_outs("opp_11", 2'b10, 2'b00, 2'b00);

        // Reset while bit0's counter sits at 5.
        sw_raw = 2'b11;
        step(7);
        check_outs("mid_7", 2'b10, 2'b00, 2'b00);
        reset_n = 1'b0;
        #1;
        check_outs("mid_rst", 2'b00, 2'b00, 2'b00);
        step(2);
        check_outs("mid_rst_held", 2'b00, 2'b00, 2'b00);
        reset_n = 1'b1;
        step(9);
        check_outs("mid_rel_9", 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("mid_rel_10", 2'b11, 2'b11, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
